// File: rtl/regfile_sb.sv
// Multi-port register file with two write ports, optional write-to-read bypass,
// and a per-register busy scoreboard for multi-cycle results.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wa_en,
    input  logic [ADDR_W-1:0]            wa_addr,
    input  logic [DATA_W-1:0]            wa_data,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         claim_en,
    input  logic [ADDR_W-1:0]            claim_addr,
    output logic [(2**ADDR_W)-1:0]       busy_vec,
    output logic                         wr_collide,
    output logic                         claim_err
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_next;
    logic              collide_next;
    logic              claim_err_next;

    assign busy_vec = busy_q;

    // Retire clears, then a same-cycle claim re-sets; register 0 never busy.
    always_comb begin
        busy_next = busy_q;
        if (wb_en) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (claim_en) begin
            busy_next[claim_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        collide_next   = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != '0);
        claim_err_next = claim_en && (claim_addr != '0) && busy_q[claim_addr]
                         && !(wb_en && (wb_addr == claim_addr));
    end

    // Port B is applied after port A so it wins on a same-address write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy_q     <= '0;
            wr_collide <= 1'b0;
            claim_err  <= 1'b0;
        end else begin
            if (wa_en && (wa_addr != '0)) begin
                mem[wa_addr] <= wa_data;
            end
            if (wb_en && (wb_addr != '0)) begin
                mem[wb_addr] <= wb_data;
            end
            busy_q     <= busy_next;
            wr_collide <= collide_next;
            claim_err  <= claim_err_next;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            if (addr == '0) begin
                data = '0;
            end else if ((BYPASS != 0) && wb_en && (wb_addr == addr)) begin
                data = wb_data;
            end else if ((BYPASS != 0) && wa_en && (wa_addr == addr)) begin
                data = wa_data;
            end else begin
                data = mem[addr];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
        assign rd_busy[p]                  = busy_q[addr];
    end

endmodule
